// File: rtl/ul_ram_pkg.sv
// Shared constants for the uplink ping-pong RAM pair: bank bases, frame
// length, sync words and the read sequencer state encoding.
package ul_ram_pkg;

  localparam int FRAME_LEN = 262;
  localparam int CNT_W     = 9;

  localparam logic [9:0]       RAM0_BASE  = 10'd0;
  localparam logic [9:0]       RAM1_BASE  = 10'd512;
  localparam logic [9:0]       SYNC_BYTE0 = 10'h287;
  localparam logic [9:0]       SYNC_BYTE1 = 10'h2b8;
  localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(FRAME_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ    = 3'd1,
    S_DRAIN   = 3'd2,
    S_RELEASE = 3'd3,
    S_GAP     = 3'd4
  } rd_state_e;

  function automatic logic [9:0] bank_base(input logic bank);
    return bank ? RAM1_BASE : RAM0_BASE;
  endfunction

endpackage

// File: rtl/ul_out_skid2.sv
// Two-entry fall-through valid/ready buffer. A word arriving into an empty
// buffer is presented in the same cycle; count_o feeds the read credit.
module ul_out_skid2 #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         nRst,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic [1:0]   count_o
);

  logic [1:0][W-1:0] mem_q, mem_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              pop;

  assign valid_o = (cnt_q != 2'd0) | push_i;
  assign data_o  = (cnt_q != 2'd0) ? mem_q[0] : (push_i ? push_data_i : '0);
  assign pop     = valid_o & ready_i;
  assign count_o = cnt_q;

  always_comb begin
    mem_d = mem_q;
    cnt_d = cnt_q;
    case ({push_i, pop})
      2'b11: begin
        // empty + push + pop is a pure pass-through
        if (cnt_q == 2'd1) begin
          mem_d[0] = push_data_i;
        end else if (cnt_q == 2'd2) begin
          mem_d[0] = mem_q[1];
          mem_d[1] = push_data_i;
        end
      end
      2'b10: begin
        if (cnt_q != 2'd2) begin
          mem_d[cnt_q[0]] = push_data_i;
          cnt_d           = cnt_q + 2'd1;
        end
      end
      2'b01: begin
        mem_d[0] = mem_q[1];
        cnt_d    = cnt_q - 2'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      mem_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ul_rd_ram_control_s.sv
// Uplink read sequencer: picks a full ping-pong bank, streams its frame to a
// valid/ready consumer and hands the bank back with a one-cycle release pulse.
module ul_rd_ram_control_s
  import ul_ram_pkg::*;
(
  input  logic       clk,
  input  logic       nRst,
  input  logic [1:0] UlRAM_wr_state,
  input  logic [9:0] rdUlRAMData,
  output logic [9:0] rdUlRAMAddr,
  output logic       rdUlRAMEn,
  output logic [1:0] UlRAM_rd_state,
  output logic [9:0] outData,
  output logic       outValid,
  input  logic       outReady,
  output logic       frameStart,
  output logic       frameEnd,
  output logic       rdBusy
);

  rd_state_e        state_q, state_d;
  logic             curBank_q, curBank_d;
  logic             lastBank_q, lastBank_d;
  logic             rdBusy_q, rdBusy_d;
  logic [CNT_W-1:0] issueCnt_q, issueCnt_d;
  logic [CNT_W-1:0] deliverCnt_q, deliverCnt_d;
  logic             vld_q;  // read issued last cycle, data returning now
  logic             issue;
  logic             accept;
  logic             credit_ok;
  logic [1:0]       buf_cnt;

  // buffered + in-flight must stay below 2 before a new read may go out
  assign credit_ok = ({1'b0, buf_cnt} + {2'b0, vld_q}) < 3'd2;
  assign accept    = outValid & outReady;
  assign rdUlRAMEn = issue;

  always_comb begin
    state_d        = state_q;
    curBank_d      = curBank_q;
    lastBank_d     = lastBank_q;
    rdBusy_d       = rdBusy_q;
    issueCnt_d     = issueCnt_q;
    deliverCnt_d   = accept ? deliverCnt_q + 1'b1 : deliverCnt_q;
    issue          = 1'b0;
    rdUlRAMAddr    = '0;
    UlRAM_rd_state = '0;
    case (state_q)
      S_IDLE: begin
        if (|UlRAM_wr_state) begin
          curBank_d    = (&UlRAM_wr_state) ? ~lastBank_q : UlRAM_wr_state[1];
          issueCnt_d   = '0;
          deliverCnt_d = '0;
          rdBusy_d     = 1'b1;
          state_d      = S_READ;
        end
      end
      S_READ: begin
        if (credit_ok) begin
          issue       = 1'b1;
          rdUlRAMAddr = bank_base(curBank_q) + 10'(issueCnt_q);
          issueCnt_d  = issueCnt_q + 1'b1;
          if (issueCnt_q == LAST_IDX) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (accept && deliverCnt_q == LAST_IDX) state_d = S_RELEASE;
      end
      S_RELEASE: begin
        UlRAM_rd_state[curBank_q] = 1'b1;
        lastBank_d                = curBank_q;
        state_d                   = S_GAP;
      end
      S_GAP: begin
        // writer drops its flag here, so IDLE never sees a stale one
        rdBusy_d = 1'b0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q      <= S_IDLE;
      curBank_q    <= 1'b0;
      lastBank_q   <= 1'b1;
      rdBusy_q     <= 1'b0;
      issueCnt_q   <= '0;
      deliverCnt_q <= '0;
      vld_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      curBank_q    <= curBank_d;
      lastBank_q   <= lastBank_d;
      rdBusy_q     <= rdBusy_d;
      issueCnt_q   <= issueCnt_d;
      deliverCnt_q <= deliverCnt_d;
      vld_q        <= issue;
    end
  end

  ul_out_skid2 #(.W(10)) u_skid (
    .clk         (clk),
    .nRst        (nRst),
    .push_i      (vld_q),
    .push_data_i (rdUlRAMData),
    .ready_i     (outReady),
    .valid_o     (outValid),
    .data_o      (outData),
    .count_o     (buf_cnt)
  );

  assign frameStart = outValid & (deliverCnt_q == '0);
  assign frameEnd   = outValid & (deliverCnt_q == LAST_IDX);
  assign rdBusy     = rdBusy_q;

endmodule

// File: tb/tb_ul_rd_ram_control_s.sv
// Scoreboard bench for the uplink read sequencer: a RAM model, a writer
// model that drops flags on release, and queued expected reads/words/pulses.
module tb_ul_rd_ram_control_s;
  import ul_ram_pkg::*;

  logic       clk = 1'b0;
  logic       nRst = 1'b0;
  logic [1:0] UlRAM_wr_state;
  logic [9:0] rdUlRAMData = '0;
  logic [9:0] rdUlRAMAddr;
  logic       rdUlRAMEn;
  logic [1:0] UlRAM_rd_state;
  logic [9:0] outData;
  logic       outValid;
  logic       outReady = 1'b1;
  logic       frameStart, frameEnd, rdBusy;

  ul_rd_ram_control_s dut (
    .clk            (clk),
    .nRst           (nRst),
    .UlRAM_wr_state (UlRAM_wr_state),
    .rdUlRAMData    (rdUlRAMData),
    .rdUlRAMAddr    (rdUlRAMAddr),
    .rdUlRAMEn      (rdUlRAMEn),
    .UlRAM_rd_state (UlRAM_rd_state),
    .outData        (outData),
    .outValid       (outValid),
    .outReady       (outReady),
    .frameStart     (frameStart),
    .frameEnd       (frameEnd),
    .rdBusy         (rdBusy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] d;
    logic       s;
    logic       e;
  } exp_t;

  exp_t       exp_q[$];
  logic [9:0] addr_q[$];
  logic [1:0] pulse_q[$];
  logic [9:0] ram[1024];

  int checks = 0, errors = 0, cyc = 0;
  int issues = 0, accs = 0, pulse_cnt = 0, pulse_cyc = -1, b1_issue_cyc = -1;
  int set_gen[2] = '{0, 0};
  int clr_gen[2] = '{0, 0};
  int hold_cyc = 0, rdy_mode = 0;

  // a bank is flagged full while the writer has set it more often than cleared
  assign UlRAM_wr_state = {set_gen[1] != clr_gen[1], set_gen[0] != clr_gen[0]};

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (rdUlRAMEn) rdUlRAMData <= ram[rdUlRAMAddr];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  // monitor / scoreboard
  initial forever begin
    @(negedge clk);
    if (!nRst) begin
      issues = 0;
      accs   = 0;
    end else begin
      if (rdUlRAMEn) begin
        chk("outstanding_le2", 32'(issues - accs + 1 <= 2), 1);
        if (addr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexp_read: got addr %0d expected no read", rdUlRAMAddr);
        end else chk("rd_addr", rdUlRAMAddr, addr_q.pop_front());
        if (rdUlRAMAddr == RAM1_BASE) b1_issue_cyc = cyc;
        issues++;
      end
      if (outValid && outReady) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexp_word: got %0d expected none", outData);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out_data", outData, e.d);
          chk("frame_start", frameStart, e.s);
          chk("frame_end", frameEnd, e.e);
        end
        accs++;
      end
      if (|UlRAM_rd_state) begin
        if (pulse_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexp_pulse: got %0d expected none", UlRAM_rd_state);
        end else chk("rd_state_pulse", UlRAM_rd_state, pulse_q.pop_front());
        pulse_cnt++;
        pulse_cyc = cyc;
      end
    end
  end

  // writer model: drops the released bank's flag hold_cyc cycles after the pulse
  initial begin
    int pend[2];
    bit act[2];
    pend = '{0, 0};
    act  = '{0, 0};
    forever begin
      @(negedge clk);
      for (int b = 0; b < 2; b++)
        if (nRst && UlRAM_rd_state[b]) begin
          act[b]  = 1'b1;
          pend[b] = hold_cyc;
        end
      @(posedge clk); #1;
      for (int b = 0; b < 2; b++)
        if (act[b]) begin
          if (pend[b] == 0) begin
            clr_gen[b] = set_gen[b];
            act[b]     = 1'b0;
          end else pend[b]--;
        end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    outReady = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
    $fatal(1, "timeout");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_flag(input int b);
    if (set_gen[b] == clr_gen[b]) set_gen[b]++;
  endtask

  task automatic push_frame(input int bank);
    logic [9:0] base;
    exp_t e;
    base = bank ? RAM1_BASE : RAM0_BASE;
    for (int i = 0; i < FRAME_LEN; i++) begin
      addr_q.push_back(base + 10'(i));
      e.d = ram[base + 10'(i)];
      e.s = (i == 0);
      e.e = (i == FRAME_LEN - 1);
      exp_q.push_back(e);
    end
    pulse_q.push_back(bank ? 2'b10 : 2'b01);
  endtask

  task automatic wait_pulses(input int n);
    int t = 0;
    while (pulse_cnt < n && t < 4000) begin step(1); t++; end
    chk("pulse_wait", 32'(pulse_cnt >= n), 1);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (rdBusy && t < 6) begin step(1); t++; end
    chk("rdBusy_falls", rdBusy, 0);
  endtask

  initial begin
    int bad, is0, p7, a0;
    for (int a = 0; a < 512; a++) ram[a] = 10'($urandom);
    for (int a = 512; a < 1024; a++) ram[a] = 10'(a);

    // reset state, both banks flagged while in reset
    set_flag(0);
    set_flag(1);
    step(3);
    chk("rst_rdEn", rdUlRAMEn, 0);
    chk("rst_addr", rdUlRAMAddr, 0);
    chk("rst_valid", outValid, 0);
    chk("rst_busy", rdBusy, 0);
    chk("rst_pulse", UlRAM_rd_state, 0);
    chk("rst_fstart", frameStart, 0);

    // bank0 first (lastBank resets to 1), then bank1
    push_frame(0);
    push_frame(1);
    nRst = 1'b1;
    wait_pulses(2);
    wait_idle();

    // bank0 only: latency and one word per cycle
    set_flag(0);
    push_frame(0);
    @(negedge clk);
    @(negedge clk);
    chk("lat_first_issue", rdUlRAMEn, 1);
    bad = 0;
    for (int i = 0; i < FRAME_LEN; i++) begin
      @(negedge clk);
      if (!outValid) bad++;
    end
    chk("throughput_gaps", bad, 0);
    chk("frameEnd_last", frameEnd, 1);
    wait_pulses(3);
    wait_idle();

    // writer holds the flag through the gap: no re-selection
    hold_cyc = 1;
    set_flag(0);
    push_frame(0);
    wait_pulses(4);
    is0 = issues;
    step(12);
    chk("no_reselect", issues, is0);
    chk("idle_busy", rdBusy, 0);
    chk("flag_dropped", UlRAM_wr_state, 0);
    hold_cyc = 0;
    set_flag(0);
    push_frame(0);
    wait_pulses(5);
    wait_idle();

    // bank1 address pattern under random backpressure
    rdy_mode = 1;
    set_flag(1);
    push_frame(1);
    wait_pulses(6);
    rdy_mode = 0;
    step(1);
    wait_idle();

    // bank1 flagged mid-frame of bank0
    set_flag(0);
    push_frame(0);
    a0 = accs;
    for (int t = 0; t < 400 && accs < a0 + 50; t++) step(1);
    set_flag(1);
    push_frame(1);
    wait_pulses(7);
    p7 = pulse_cyc;
    wait_pulses(8);
    chk("b1_start_after_gap", 32'(b1_issue_cyc - p7), 3);
    wait_idle();

    // reset at word 100 of a bank0 frame
    set_flag(0);
    push_frame(0);
    a0 = accs;
    for (int t = 0; t < 400 && accs < a0 + 100; t++) step(1);
    chk("reached_word100", 32'(accs >= a0 + 100), 1);
    nRst = 1'b0;
    #1;
    chk("arst_valid", outValid, 0);
    chk("arst_rdEn", rdUlRAMEn, 0);
    chk("arst_busy", rdBusy, 0);
    chk("arst_data", outData, 0);
    chk("arst_fstart", frameStart, 0);
    exp_q.delete();
    addr_q.delete();
    pulse_q.delete();
    a0 = pulse_cnt;
    step(3);
    chk("no_pulse_in_reset", pulse_cnt, a0);
    push_frame(0);
    nRst = 1'b1;
    wait_pulses(a0 + 1);
    wait_idle();

    step(5);
    chk("exp_q_empty", exp_q.size(), 0);
    chk("addr_q_empty", addr_q.size(), 0);
    chk("pulse_q_empty", pulse_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ul_rd_ram_control_s.md
Name: ul_rd_ram_control_s

Overview:
Read-side sequencer for the uplink ping-pong RAM pair (bank0 at addresses 0..261, bank1 at 512..773) filled by the surface uplink write controller.
- Watches the per-bank write-full flags and picks a full bank.
- Streams its FRAME_LEN 10-bit words in address order to a downstream valid/ready consumer (encoder or host FIFO).
- Releases the bank to the writer with a one-cycle read-done pulse on UlRAM_rd_state.
- Absorbs the 1-cycle RAM read latency and downstream backpressure with a 2-entry output buffer.

Parameters:
FRAME_LEN, 262, words per frame (including the two sync words)
RAM0_BASE, 10'd0, first address of bank0
RAM1_BASE, 10'd512, first address of bank1

Ports:
clk  in  1  system clock
nRst  in  1  asynchronous active-low reset
UlRAM_wr_state  in  2  per-bank full flag from the write controller (1 = full)
rdUlRAMData  in  10  RAM read data, valid exactly 1 cycle after rdUlRAMEn
rdUlRAMAddr  out  10  RAM read address
rdUlRAMEn  out  1  RAM read strobe
UlRAM_rd_state  out  2  one-cycle pulse per bank: bank read complete
outData  out  10  streamed word
outValid  out  1  outData valid
outReady  in  1  downstream accepts when outValid && outReady
frameStart  out  1  high with the first word of a frame (qualified by outValid)
frameEnd  out  1  high with the last word of a frame (qualified by outValid)
rdBusy  out  1  high from bank selection until the release completes

Behaviour:
- Clock and reset: one clock, clk. Reset nRst is asynchronous, active-low.
- Reset values: all outputs 0; rdUlRAMAddr = 0; state S_IDLE; lastBank = 1, so bank0 is served first.
- States: S_IDLE, S_READ, S_DRAIN, S_RELEASE, S_GAP.
- S_IDLE, bank selection:
  - Only one flag set: select that bank.
  - Both set: select the bank != lastBank.
  - On selection: latch curBank, load the base address, clear issueCnt and deliverCnt, set rdBusy, go to S_READ.
  - No flag set: stay in S_IDLE.
- S_READ:
  - Issue a read (rdUlRAMEn = 1, rdUlRAMAddr = base + issueCnt) only when buffered words + in-flight reads < 2.
  - issueCnt increments on each issue.
  - When issueCnt reaches FRAME_LEN-1 and that read issues, go to S_DRAIN.
- Return path: data returns 1 cycle after issue and is pushed into the 2-entry buffer.
  - Buffer head drives outData/outValid.
  - Pop on outValid && outReady.
  - Push and pop in the same cycle are both legal.
  - The credit rule above guarantees the buffer never overflows.
- Frame markers: frameStart is high while deliverCnt == 0. frameEnd is high while deliverCnt == FRAME_LEN-1. deliverCnt increments on each accepted word.
- S_DRAIN: no reads issued. On acceptance of the FRAME_LEN-th word, go to S_RELEASE.
- S_RELEASE, one cycle: UlRAM_rd_state[curBank] = 1; set lastBank = curBank; go to S_GAP.
- S_GAP, one cycle: lets the writer drop its full flag so the same bank is never re-selected on a stale flag. Then clear rdBusy and go to S_IDLE.
- Throughput: with outReady held high, one word per cycle after a 1-cycle initial latency.
  - Cycle 0: S_IDLE selects.
  - Cycle 1: first issue.
  - Cycle 2: first outValid.
- Backpressure: outReady low freezes delivery; at most 2 reads are outstanding or buffered. Data order is preserved.
- Flag changes mid-frame: a new full flag on the other bank is ignored until S_IDLE. The curBank flag dropping mid-frame does not abort the frame.
- Timeout-forced frames from the writer (flag set before the bank is full) are still read as FRAME_LEN words; stale tail words are passed through unchanged.
- Address arithmetic is 10-bit; base + FRAME_LEN-1 stays within the bank, so no wrap-around.
- Reset mid-frame clears the buffer, counters and outputs immediately. No release pulse is produced for the interrupted bank.

Decomposition:
- Shared package ul_ram_pkg:
  - RAM0_BASE / RAM1_BASE
  - FRAME_LEN
  - SYNC_BYTE 10'h287 / 10'h2b8
  - state encoding constants
- Sub-module ul_out_skid2: the 2-entry valid/ready output buffer, with count output used for credit.

Test Plan:
- Bank0 full only, outReady = 1:
  - Reads at addresses 0..261.
  - 262 words with outValid on consecutive cycles; frameStart on word 0, frameEnd on word 261.
  - UlRAM_rd_state = 2'b01 for exactly one cycle; rdBusy then falls.
- Both flags set at reset release: bank0 served fully (addresses 0..261), then bank1 (512..773), with pulse 01 followed by pulse 10.
- Bank1 data = address pattern, outReady toggled 1-0-0-1 randomly: outData sequence exactly 512..773 with no loss or duplicate; at most 2 reads outstanding at any time.
- Writer keeps bank0 flag high 1 cycle after the pulse: no re-selection of bank0 during S_GAP; the next frame starts only on a fresh flag.
- Reset asserted at word 100 of a bank0 frame:
  - Outputs go to 0 asynchronously; no rd_state pulse.
  - After reset, bank0 (still flagged) is re-read from address 0.
- Bank1 flag rises while bank0 is mid-frame: bank0 completes all 262 words, then bank1 starts in the cycle after S_GAP.
